// File: rtl/debug_link_pkg.sv
// Shared types for the debug host link: command ops, UART opcodes,
// FSM states and word-size helper.
package debug_link_pkg;

  typedef enum logic [1:0] {
    OP_CONFIG    = 2'd0,
    OP_DUMP      = 2'd1,
    OP_TRACE_ON  = 2'd2,
    OP_TRACE_OFF = 2'd3
  } cmd_op_e;

  localparam logic [7:0] CMD_CONFIG    = 8'h01;
  localparam logic [7:0] CMD_DUMP      = 8'h02;
  localparam logic [7:0] CMD_TRACE_ON  = 8'h03;
  localparam logic [7:0] CMD_TRACE_OFF = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_GUARD,
    S_RECV
  } state_e;

  function automatic int BYTES_PER_WORD(input int dw);
    return dw / 8;
  endfunction

  function automatic logic [7:0] opcode_byte(input cmd_op_e op);
    logic [7:0] b;
    b = CMD_CONFIG;
    unique case (op)
      OP_CONFIG:    b = CMD_CONFIG;
      OP_DUMP:      b = CMD_DUMP;
      OP_TRACE_ON:  b = CMD_TRACE_ON;
      OP_TRACE_OFF: b = CMD_TRACE_OFF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/debug_host_link_if.sv
// Command handshake plus UART byte link between host emulator and
// its environment.
interface debug_host_link_if;
  import debug_link_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  cmd_op_e    cmd_op;
  logic [7:0] cmd_id;
  logic [7:0] cmd_data;
  logic [7:0] tx_data;
  logic       new_tx_data;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       new_rx_data;

  modport master (
    input  cmd_valid, cmd_op, cmd_id, cmd_data,
    input  tx_busy, rx_data, new_rx_data,
    output cmd_ready, tx_data, new_tx_data
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_id, cmd_data,
    output tx_busy, rx_data, new_rx_data,
    input  cmd_ready, tx_data, new_tx_data
  );

endinterface

// File: rtl/trace_vector_assembler.sv
// Packs the dump byte stream LSB-first into N-wide trace vectors and
// watches for stalled streams.
module trace_vector_assembler
  import debug_link_pkg::*;
#(
  parameter int N              = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TB_SIZE        = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int AW = (TB_SIZE > 1) ? $clog2(TB_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  new_rx_data,
  output logic                  vec_valid,
  output logic [AW-1:0]         vec_addr,
  output logic [DATA_WIDTH-1:0] vector_out [N-1:0],
  output logic                  dump_done,
  output logic                  timeout_err
);

  localparam int BPW = BYTES_PER_WORD(DATA_WIDTH);
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int EW  = (N > 1) ? $clog2(N) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BW-1:0] BYTE_LAST = BW'(BPW - 1);
  localparam logic [EW-1:0] ELEM_LAST = EW'(N - 1);
  localparam logic [AW-1:0] VEC_LAST  = AW'(TB_SIZE - 1);
  localparam logic [TW-1:0] TIME_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic                  run;
  logic [BW-1:0]         byte_idx;
  logic [EW-1:0]         elem_idx;
  logic [AW-1:0]         vec_idx;
  logic [TW-1:0]         timer;
  logic [DATA_WIDTH-1:0] work      [N-1:0];
  logic [DATA_WIDTH-1:0] next_work [N-1:0];

  logic take, word_end, vec_end, dump_end, expire;

  assign take     = run && new_rx_data;
  assign word_end = (byte_idx == BYTE_LAST);
  assign vec_end  = word_end && (elem_idx == ELEM_LAST);
  assign dump_end = vec_end && (vec_idx == VEC_LAST);
  // An arriving byte always beats an expiring timer.
  assign expire   = run && !new_rx_data
                 && (timer + 1'b1 == TIME_LAST);

  always_comb begin
    next_work = work;
    next_work[elem_idx][8*byte_idx +: 8] = rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run         <= 1'b0;
      byte_idx    <= '0;
      elem_idx    <= '0;
      vec_idx     <= '0;
      timer       <= '0;
      vec_valid   <= 1'b0;
      vec_addr    <= '0;
      dump_done   <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < N; i++) begin
        work[i]       <= '0;
        vector_out[i] <= '0;
      end
    end else begin
      vec_valid   <= 1'b0;
      dump_done   <= 1'b0;
      timeout_err <= 1'b0;
      if (start) begin
        run      <= 1'b1;
        byte_idx <= '0;
        elem_idx <= '0;
        vec_idx  <= '0;
        timer    <= '0;
      end else if (take) begin
        timer    <= '0;
        work     <= next_work;
        byte_idx <= word_end ? '0 : byte_idx + 1'b1;
        if (word_end)
          elem_idx <= (elem_idx == ELEM_LAST) ? '0 : elem_idx + 1'b1;
        if (vec_end) begin
          vector_out <= next_work;
          vec_valid  <= 1'b1;
          vec_addr   <= vec_idx;
          vec_idx    <= dump_end ? '0 : vec_idx + 1'b1;
        end
        if (dump_end) begin
          dump_done <= 1'b1;
          run       <= 1'b0;
        end
      end else if (run) begin
        timer <= timer + 1'b1;
        if (expire) begin
          timeout_err <= 1'b1;
          run         <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/debug_host_link.sv
// Host emulator: serialises debugger commands onto the UART link and
// hands dump traffic to the vector assembler.
module debug_host_link
  import debug_link_pkg::*;
#(
  parameter int N              = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TB_SIZE        = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int AW = (TB_SIZE > 1) ? $clog2(TB_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  debug_host_link_if.master     link,
  output logic                  vec_valid,
  output logic [AW-1:0]         vec_addr,
  output logic [DATA_WIDTH-1:0] vector_out [N-1:0],
  output logic                  dump_done,
  output logic                  timeout_err
);

  state_e     state, state_n;
  cmd_op_e    op_q;
  logic [7:0] id_q;
  logic [7:0] data_q;
  logic [1:0] byte_idx;
  logic [7:0] tx_q;
  logic [7:0] cur_byte;
  logic       last_byte;
  logic       recv_start;

  assign last_byte    = (op_q == OP_CONFIG) ? (byte_idx == 2'd2) : 1'b1;
  assign link.tx_data = tx_q;

  always_comb begin
    cur_byte = opcode_byte(op_q);
    unique case (byte_idx)
      2'd1:    cur_byte = id_q;
      2'd2:    cur_byte = data_q;
      default: cur_byte = opcode_byte(op_q);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= OP_CONFIG;
      id_q     <= '0;
      data_q   <= '0;
      byte_idx <= '0;
      tx_q     <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && link.cmd_valid) begin
        op_q     <= link.cmd_op;
        id_q     <= link.cmd_id;
        data_q   <= link.cmd_data;
        byte_idx <= '0;
      end
      if (state == S_LOAD)
        tx_q <= cur_byte;
      if (state == S_GUARD && !last_byte)
        byte_idx <= byte_idx + 2'd1;
    end
  end

  // GUARD gives the transmitter a cycle to raise tx_busy.
  always_comb begin
    state_n          = state;
    link.cmd_ready   = 1'b0;
    link.new_tx_data = 1'b0;
    recv_start       = 1'b0;
    unique case (state)
      S_IDLE: begin
        link.cmd_ready = 1'b1;
        if (link.cmd_valid)
          state_n = S_LOAD;
      end
      S_LOAD:
        state_n = S_SEND;
      S_SEND: begin
        if (!link.tx_busy) begin
          link.new_tx_data = 1'b1;
          state_n          = S_GUARD;
        end
      end
      S_GUARD: begin
        if (!last_byte) begin
          state_n = S_LOAD;
        end else if (op_q == OP_DUMP) begin
          state_n    = S_RECV;
          recv_start = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_RECV: begin
        if (dump_done || timeout_err)
          state_n = S_IDLE;
      end
      default:
        state_n = S_IDLE;
    endcase
  end

  trace_vector_assembler #(
    .N              (N),
    .DATA_WIDTH     (DATA_WIDTH),
    .TB_SIZE        (TB_SIZE),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_asm (
    .clk         (clk),
    .reset       (reset),
    .start       (recv_start),
    .rx_data     (link.rx_data),
    .new_rx_data (link.new_rx_data),
    .vec_valid   (vec_valid),
    .vec_addr    (vec_addr),
    .vector_out  (vector_out),
    .dump_done   (dump_done),
    .timeout_err (timeout_err)
  );

endmodule

// File: tb/tb_debug_host_link.sv
// Scoreboard bench for debug_host_link: directed commands and dump
// streams, with a monitor checking every tx byte, vector and timeout.
module tb_debug_host_link;
  import debug_link_pkg::*;

  typedef struct {
    logic [0:0]  addr;
    logic [15:0] e0;
    logic [15:0] e1;
    logic        done;
  } vexp_t;

  logic        clk;
  logic        reset;
  logic        vec_valid;
  logic [0:0]  vec_addr;
  logic [15:0] vector_out [1:0];
  logic        dump_done;
  logic        timeout_err;

  debug_host_link_if link();

  debug_host_link #(
    .N              (2),
    .DATA_WIDTH     (16),
    .TB_SIZE        (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .link        (link),
    .vec_valid   (vec_valid),
    .vec_addr    (vec_addr),
    .vector_out  (vector_out),
    .dump_done   (dump_done),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int tx_strobes = 0;
  int vec_count = 0;
  int to_count = 0;
  int last_rx = 0;
  logic [7:0] txq [$];
  vexp_t      vq  [$];
  int         toq [$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [7:0] b;
    vexp_t v;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (link.new_rx_data) last_rx = cyc;
        if (link.new_tx_data) begin
          tx_strobes++;
          chk("tx_while_busy", link.tx_busy, 0);
          if (txq.size() == 0) chk("tx_unexpected", 1, 0);
          else begin
            b = txq.pop_front();
            chk("tx_byte", link.tx_data, b);
          end
        end
        if (vec_valid) begin
          vec_count++;
          if (vq.size() == 0) chk("vec_unexpected", 1, 0);
          else begin
            v = vq.pop_front();
            chk("vec_addr", vec_addr, v.addr);
            chk("vec_e0", vector_out[0], v.e0);
            chk("vec_e1", vector_out[1], v.e1);
            chk("vec_done", dump_done, v.done);
          end
        end
        if (dump_done && !vec_valid) chk("done_alone", 1, 0);
        if (timeout_err) begin
          to_count++;
          chk("timeout_no_vec", vec_valid, 0);
          if (toq.size() == 0) chk("timeout_unexpected", 1, 0);
          else begin
            void'(toq.pop_front());
            chk("timeout_delay", cyc - last_rx, 16);
          end
        end
      end
    end
  endtask

  task automatic issue(input cmd_op_e op, input logic [7:0] id,
                       input logic [7:0] data);
    @(posedge clk); #1;
    link.cmd_valid = 1'b1;
    link.cmd_op    = op;
    link.cmd_id    = id;
    link.cmd_data  = data;
    @(posedge clk); #1;
    link.cmd_valid = 1'b0;
    chk("ready_drop", link.cmd_ready, 0);
  endtask

  task automatic wait_ready(input int bound, output int n);
    n = 0;
    while (!link.cmd_ready && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    if (!link.cmd_ready) chk("ready_wait_expired", 0, 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    link.rx_data     = b;
    link.new_rx_data = 1'b1;
    @(posedge clk); #1;
    link.new_rx_data = 1'b0;
  endtask

  task automatic push_vec(input logic [0:0] a, input logic [15:0] e0,
                          input logic [15:0] e1, input logic d);
    vexp_t v;
    v.addr = a; v.e0 = e0; v.e1 = e1; v.done = d;
    vq.push_back(v);
  endtask

  initial begin
    int n;
    int s0;
    logic [7:0] seq [8];
    reset            = 1'b1;
    link.cmd_valid   = 1'b0;
    link.cmd_op      = OP_CONFIG;
    link.cmd_id      = '0;
    link.cmd_data    = '0;
    link.tx_busy     = 1'b0;
    link.rx_data     = '0;
    link.new_rx_data = 1'b0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_ready", link.cmd_ready, 1);
    chk("rst_new_tx", link.new_tx_data, 0);
    chk("rst_tx_data", link.tx_data, 0);
    chk("rst_vec_valid", vec_valid, 0);
    chk("rst_vec_addr", vec_addr, 0);
    chk("rst_vec0", vector_out[0], 0);
    chk("rst_vec1", vector_out[1], 0);
    chk("rst_done", dump_done, 0);
    chk("rst_timeout", timeout_err, 0);

    // CONFIG id=02 data=05
    s0 = tx_strobes;
    txq.push_back(8'h01); txq.push_back(8'h02); txq.push_back(8'h05);
    issue(OP_CONFIG, 8'h02, 8'h05);
    wait_ready(200, n);
    chk("config_cycles", n, 9);
    chk("config_strobes", tx_strobes - s0, 3);

    // TRACE_ON held off by tx_busy
    link.tx_busy = 1'b1;
    s0 = tx_strobes;
    txq.push_back(8'h03);
    issue(OP_TRACE_ON, 8'h00, 8'h00);
    repeat (20) @(posedge clk);
    #1;
    chk("busy_no_strobe", tx_strobes - s0, 0);
    link.tx_busy = 1'b0;
    wait_ready(50, n);
    chk("trace_on_strobes", tx_strobes - s0, 1);

    // Stray rx bytes in IDLE and during SEND
    s0 = vec_count;
    for (int i = 0; i < 4; i++) send_byte(8'hE0 + 8'(i));
    chk("stray_idle_ready", link.cmd_ready, 1);
    link.tx_busy = 1'b1;
    txq.push_back(8'h04);
    issue(OP_TRACE_OFF, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) send_byte(8'hF0 + 8'(i));
    link.tx_busy = 1'b0;
    wait_ready(50, n);
    chk("stray_no_vec", vec_count - s0, 0);

    // Full dump
    s0 = vec_count;
    txq.push_back(8'h02);
    push_vec(1'b0, 16'h0201, 16'h0403, 1'b0);
    push_vec(1'b1, 16'h0605, 16'h0807, 1'b1);
    issue(OP_DUMP, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1));
    wait_ready(50, n);
    chk("dump_vec_count", vec_count - s0, 2);

    // Truncated dump times out
    s0 = vec_count;
    txq.push_back(8'h02);
    toq.push_back(1);
    issue(OP_DUMP, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
    wait_ready(60, n);
    chk("timeout_count", to_count, 1);
    chk("timeout_vec_count", vec_count - s0, 0);

    // Reset mid-RECV, then a clean dump
    txq.push_back(8'h02);
    push_vec(1'b0, 16'h2211, 16'h4433, 1'b0);
    issue(OP_DUMP, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    for (int i = 0; i < 5; i++) send_byte(8'h11 * 8'(i + 1));
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("mid_rst_ready", link.cmd_ready, 1);
    chk("mid_rst_addr", vec_addr, 0);
    chk("mid_rst_vec0", vector_out[0], 0);
    chk("mid_rst_vec1", vector_out[1], 0);
    s0 = vec_count;
    txq.push_back(8'h02);
    push_vec(1'b0, 16'hA2A1, 16'hA4A3, 1'b0);
    push_vec(1'b1, 16'hA6A5, 16'hA8A7, 1'b1);
    seq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
    issue(OP_DUMP, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    for (int i = 0; i < 8; i++) send_byte(seq[i]);
    wait_ready(50, n);
    chk("post_rst_vec_count", vec_count - s0, 2);

    repeat (4) @(posedge clk);
    chk("txq_drained", txq.size(), 0);
    chk("vq_drained", vq.size(), 0);
    chk("toq_drained", toq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
